// File: rtl/sha2_pkg.sv
// Shared SHA-2 egress definitions: variant encoding, digest lengths in 32-bit words, egress FSM states.
package sha2_pkg;

   typedef enum logic [1:0] {
      SHA224 = 2'b00,
      SHA256 = 2'b01,
      SHA384 = 2'b10,
      SHA512 = 2'b11
   } sha_type_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int DIGEST_WORDS [4] = '{7, 8, 12, 16};

   function automatic logic [3:0] last_idx(input sha_type_t t);
      return 4'(DIGEST_WORDS[t] - 1);
   endfunction

endpackage

// File: rtl/hash_digest_out_word_sel.sv
// Combinational digest word picker: big-endian 32-bit word k of the snapshot for the given variant.
// Kept standalone so a register-read path can share the same mapping.
module digest_word_sel (
   input  logic [63:0] i_snap [0:7],
   input  logic [1:0]  i_type,
   input  logic [3:0]  i_idx,
   output logic [31:0] o_word
);

   logic [63:0] w_dw;

   always_comb begin
      w_dw   = 64'h0;
      o_word = 32'h0;
      if (i_type[1]) begin
         // 64-bit variants: high half of each hash word goes out first
         w_dw   = i_snap[i_idx[3:1]];
         o_word = i_idx[0] ? w_dw[31:0] : w_dw[63:32];
      end else begin
         w_dw   = i_snap[i_idx[2:0]];
         o_word = w_dw[31:0];
      end
   end

endmodule

// File: rtl/hash_digest_out.sv
// Digest egress: snapshots H on start, streams N big-endian words (1 cycle start latency, 1 word/cycle).
// Holds tdata/tlast under backpressure; a start on the final handshake chains the next digest without a gap.
module hash_digest_out
   import sha2_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  sha_type,
   input  logic        start,
   input  logic [63:0] H [0:7],
   output logic        busy,
   output logic [31:0] dout_tdata,
   output logic        dout_tvalid,
   input  logic        dout_tready,
   output logic        dout_tlast,
   output logic        digest_done,
   output logic        start_err
);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [63:0] r_snap [0:7];
   sha_type_t   r_type;
   logic        r_busy;
   logic [31:0] r_tdata;
   logic        r_tvalid;
   logic        r_tlast;
   logic        r_done;
   logic        r_err;

   logic        w_hs;
   logic        w_fin;
   logic        w_accept;
   logic        w_err;
   state_t      w_nxt_state;
   logic [3:0]  w_nxt_cnt;
   sha_type_t   w_nxt_type;
   logic [63:0] w_sel_snap [0:7];
   logic [31:0] w_word;

   assign w_hs     = r_tvalid & dout_tready;
   assign w_fin    = w_hs & (r_cnt == last_idx(r_type));
   assign w_accept = start & ((r_state == IDLE) | w_fin);
   assign w_err    = start & (r_state == SEND) & ~w_fin;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_type  = r_type;
      if (w_accept) begin
         w_nxt_state = SEND;
         w_nxt_cnt   = 4'd0;
         w_nxt_type  = sha_type_t'(sha_type);
      end else if (w_fin) begin
         w_nxt_state = IDLE;
      end else if (w_hs) begin
         w_nxt_cnt   = r_cnt + 4'd1;
      end
   end

   // Select from the incoming H on accept so the first word is ready the very next cycle
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_sel_snap[i] = w_accept ? H[i] : r_snap[i];
      end
   end

   digest_word_sel u_word_sel (
      .i_snap (w_sel_snap),
      .i_type (w_nxt_type),
      .i_idx  (w_nxt_cnt),
      .o_word (w_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_type   <= SHA224;
         for (int i = 0; i < 8; i++) begin
            r_snap[i] <= 64'h0;
         end
         r_busy   <= 1'b0;
         r_tdata  <= 32'h0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_type  <= w_nxt_type;
         if (w_accept) begin
            for (int i = 0; i < 8; i++) begin
               r_snap[i] <= H[i];
            end
         end
         r_busy   <= (w_nxt_state == SEND);
         r_tvalid <= (w_nxt_state == SEND);
         r_tdata  <= (w_nxt_state == SEND) ? w_word : 32'h0;
         r_tlast  <= (w_nxt_state == SEND) && (w_nxt_cnt == last_idx(w_nxt_type));
         r_done   <= w_fin;
         r_err    <= w_err;
      end
   end

   assign busy        = r_busy;
   assign dout_tdata  = r_tdata;
   assign dout_tvalid = r_tvalid;
   assign dout_tlast  = r_tlast;
   assign digest_done = r_done;
   assign start_err   = r_err;

endmodule

// File: tb/tb_hash_digest_out.sv
// Scoreboard bench for hash_digest_out: known "abc" digests plus randomized digests against a word-mapping model.
module tb_hash_digest_out;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  sha_type;
   logic        start;
   logic [63:0] H [0:7];
   logic        busy;
   logic [31:0] dout_tdata;
   logic        dout_tvalid;
   logic        dout_tready;
   logic        dout_tlast;
   logic        digest_done;
   logic        start_err;

   hash_digest_out dut (
      .clk         (clk),
      .reset       (reset),
      .sha_type    (sha_type),
      .start       (start),
      .H           (H),
      .busy        (busy),
      .dout_tdata  (dout_tdata),
      .dout_tvalid (dout_tvalid),
      .dout_tready (dout_tready),
      .dout_tlast  (dout_tlast),
      .digest_done (digest_done),
      .start_err   (start_err)
   );

   always #5 clk = ~clk;

   logic [31:0] ABC256 [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   logic [31:0] ABC224 [7] = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                               32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7};
   logic [31:0] ABC384 [12] = '{32'hcb00753f, 32'h45a35e8b, 32'hb5a03d69, 32'h9ac65007,
                                32'h272c32ab, 32'h0eded163, 32'h1a8b605a, 32'h43ff5bed,
                                32'h8086072b, 32'ha1e7cc23, 32'h58baeca1, 32'h34c825a7};
   logic [63:0] ABC512 [8] = '{64'hddaf35a193617aba, 64'hcc417349ae204131,
                               64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                               64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                               64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

   int          total = 0;
   int          bad   = 0;
   logic [32:0] exp_q [$];
   int          hs_cnt   = 0;
   int          done_cnt = 0;
   int          rdy_mode = 0;
   int          rdy_phase = 0;
   logic        done_exp = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;
   logic [32:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: digest length and big-endian word order straight from the SHA-2 variant rules
   task automatic push_model(input logic [1:0] t);
      int n;
      logic [31:0] w;
      n = (t == 2'd0) ? 7 : (t == 2'd1) ? 8 : (t == 2'd2) ? 12 : 16;
      for (int k = 0; k < n; k++) begin
         if (t >= 2'd2) w = (k % 2 == 0) ? H[k / 2][63:32] : H[k / 2][31:0];
         else           w = H[k][31:0];
         exp_q.push_back({(k == n - 1), w});
      end
   endtask

   task automatic rand_h();
      for (int i = 0; i < 8; i++) H[i] = {$urandom, $urandom};
   endtask

   // Monitor: pops the scoreboard on every handshake, checks timing side-signals every cycle
   always @(negedge clk) begin
      if (reset) begin
         done_exp   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("done_timing", 64'(digest_done), 64'(done_exp));
         if (digest_done) done_cnt++;
         if (!dout_tvalid) chk("idle_zero", {dout_tlast, dout_tdata}, 64'h0);
         if (prev_stall && dout_tvalid) chk("stall_stable", 64'(dout_tdata), 64'(prev_data));
         done_exp = 1'b0;
         if (dout_tvalid && dout_tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h expected no word", dout_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word", 64'(dout_tdata), 64'(mon_e[31:0]));
               chk("tlast", 64'(dout_tlast), 64'(mon_e[32]));
            end
            done_exp = dout_tlast;
         end
         prev_stall = dout_tvalid && !dout_tready;
         prev_data  = dout_tdata;
      end
   end

   initial begin
      dout_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: dout_tready = 1'b1;
            1: begin
               dout_tready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
               rdy_phase++;
            end
            default: dout_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] t);
      sha_type = t;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("first_valid_latency", 64'(dout_tvalid), 64'h1);
      chk("busy_on_start", 64'(busy), 64'h1);
   endtask

   task automatic drain(input int base_done, input int n_done);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
         exp_q.delete();
      end
      tick();
      tick();
      chk("busy_after", 64'(busy), 64'h0);
      chk("valid_after", 64'(dout_tvalid), 64'h0);
      chk("done_count", 64'(done_cnt), 64'(base_done + n_done));
   endtask

   task automatic wait_hs(input int target);
      int n = 0;
      while (hs_cnt < target && n < 1000) begin
         tick();
         n++;
      end
      if (hs_cnt < target) begin
         total++;
         bad++;
         $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_cnt, target);
      end
   endtask

   initial begin
      int base;
      int nw;
      logic [1:0] t;
      logic [31:0] first_b;
      reset    = 1'b1;
      start    = 1'b0;
      sha_type = 2'b00;
      for (int i = 0; i < 8; i++) H[i] = 64'h0;
      tick(); tick(); tick();
      chk("rst_busy",  64'(busy), 64'h0);
      chk("rst_data",  64'(dout_tdata), 64'h0);
      chk("rst_valid", 64'(dout_tvalid), 64'h0);
      chk("rst_last",  64'(dout_tlast), 64'h0);
      chk("rst_done",  64'(digest_done), 64'h0);
      chk("rst_err",   64'(start_err), 64'h0);
      reset = 1'b0;
      tick(); tick();

      // SHA-256 "abc": upper halves are garbage and must be ignored
      for (int i = 0; i < 8; i++) H[i] = {$urandom, ABC256[i]};
      for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), ABC256[k]});
      base = done_cnt;
      pulse_start(2'b01);
      drain(base, 1);

      // SHA-224 "abc": H[7] is never emitted
      for (int i = 0; i < 7; i++) H[i] = {$urandom, ABC224[i]};
      H[7] = 64'hdeadbeefcafef00d;
      for (int k = 0; k < 7; k++) exp_q.push_back({(k == 6), ABC224[k]});
      base = done_cnt;
      pulse_start(2'b00);
      drain(base, 1);

      // SHA-384 "abc" with tready toggling 1,0,0,1
      for (int i = 0; i < 6; i++) H[i] = {ABC384[2 * i], ABC384[2 * i + 1]};
      H[6] = {$urandom, $urandom};
      H[7] = {$urandom, $urandom};
      for (int k = 0; k < 12; k++) exp_q.push_back({(k == 11), ABC384[k]});
      rdy_phase = 0;
      rdy_mode  = 1;
      base = done_cnt;
      pulse_start(2'b10);
      drain(base, 1);
      rdy_mode = 0;

      // SHA-512 "abc": H and sha_type disturbed right after start must not matter
      for (int i = 0; i < 8; i++) H[i] = ABC512[i];
      for (int k = 0; k < 16; k++)
         exp_q.push_back({(k == 15), (k % 2 == 0) ? ABC512[k / 2][63:32] : ABC512[k / 2][31:0]});
      base = done_cnt;
      pulse_start(2'b11);
      for (int i = 0; i < 8; i++) H[i] = 64'h0;
      sha_type = 2'b00;
      drain(base, 1);

      // Overrun: start during word 3 of a SHA-256 stream is rejected
      rand_h();
      push_model(2'b01);
      base = done_cnt;
      nw = hs_cnt;
      pulse_start(2'b01);
      wait_hs(nw + 3);
      rand_h();
      sha_type = 2'b11;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_err_pulse", 64'(start_err), 64'h1);
      tick();
      chk("start_err_clear", 64'(start_err), 64'h0);
      drain(base, 1);

      // Start coincident with the final handshake chains with no valid gap
      rand_h();
      t = 2'($urandom_range(0, 3));
      push_model(t);
      base = done_cnt;
      pulse_start(t);
      nw = 0;
      while (!(dout_tvalid && dout_tlast) && nw < 100) begin
         tick();
         nw++;
      end
      chk("saw_tlast", 64'(dout_tvalid && dout_tlast), 64'h1);
      rand_h();
      t = 2'($urandom_range(0, 3));
      first_b = (t >= 2'd2) ? H[0][63:32] : H[0][31:0];
      push_model(t);
      sha_type = t;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("chain_err", 64'(start_err), 64'h0);
      chk("chain_valid", 64'(dout_tvalid), 64'h1);
      chk("chain_first", 64'(dout_tdata), 64'(first_b));
      drain(base, 2);

      // Reset at word 5 of SHA-512 discards the stream
      rand_h();
      push_model(2'b11);
      base = done_cnt;
      nw = hs_cnt;
      pulse_start(2'b11);
      wait_hs(nw + 5);
      reset = 1'b1;
      tick();
      exp_q.delete();
      chk("rst_mid_valid", 64'(dout_tvalid), 64'h0);
      chk("rst_mid_last", 64'(dout_tlast), 64'h0);
      chk("rst_mid_busy", 64'(busy), 64'h0);
      reset = 1'b0;
      tick(); tick();
      chk("rst_mid_done", 64'(done_cnt), 64'(base));
      rand_h();
      push_model(2'b01);
      base = done_cnt;
      pulse_start(2'b01);
      drain(base, 1);

      // Randomized digests with random backpressure
      rdy_mode = 2;
      for (int r = 0; r < 8; r++) begin
         rand_h();
         t = 2'($urandom_range(0, 3));
         push_model(t);
         base = done_cnt;
         pulse_start(t);
         drain(base, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
